// File: rtl/reg_slice_pkg.sv
// Shared types for the reg_slice two-entry register slice.
package reg_slice_pkg;

    localparam int unsigned LEVEL_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Number of words held in a given occupancy state.
    function automatic logic [LEVEL_W-1:0] level_of(input state_e s);
        case (s)
            ONE:     return LEVEL_W'(1);
            FULL:    return LEVEL_W'(2);
            default: return LEVEL_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/reg_slice_ctrl.sv
// Occupancy FSM for reg_slice; produces load enables for main and skid.
// Optional synchronous flush when REG_SLICE_FLUSH_EN is defined.
module reg_slice_ctrl
    import reg_slice_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    input  logic               out_ready,
`ifdef REG_SLICE_FLUSH_EN
    input  logic               flush,
`endif
    output logic               in_ready,
    output logic               out_valid,
    output logic [LEVEL_W-1:0] level,
    output logic               load_main_c,
    output logic               main_from_skid_c,
    output logic               load_skid_c
);

    state_e state_q;
    state_e state_d;
    logic   flush_c;
    logic   in_fire_c;
    logic   out_fire_c;

`ifdef REG_SLICE_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    // Handshake outputs decode state flops only, so no input reaches an output.
    assign in_ready   = (state_q != FULL);
    assign out_valid  = (state_q != EMPTY);
    assign level      = level_of(state_q);
    assign in_fire_c  = in_valid & in_ready;
    assign out_fire_c = out_valid & out_ready;

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and load enables; flush discards occupancy but leaves data alone.
    always_comb begin
        state_d          = state_q;
        load_main_c      = 1'b0;
        main_from_skid_c = 1'b0;
        load_skid_c      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire_c) begin
                    load_main_c = 1'b1;
                    state_d     = ONE;
                end
            end
            ONE: begin
                case ({in_fire_c, out_fire_c})
                    2'b10: begin
                        load_skid_c = 1'b1;
                        state_d     = FULL;
                    end
                    2'b01: state_d = EMPTY;
                    2'b11: load_main_c = 1'b1;
                    default: state_d = ONE;
                endcase
            end
            FULL: begin
                if (out_fire_c) begin
                    load_main_c      = 1'b1;
                    main_from_skid_c = 1'b1;
                    state_d          = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush_c) begin
            state_d          = EMPTY;
            load_main_c      = 1'b0;
            main_from_skid_c = 1'b0;
            load_skid_c      = 1'b0;
        end
    end

endmodule

// File: rtl/reg_slice.sv
// Two-entry (main + skid) valid/ready register slice, full throughput,
// no combinational input-to-output path.
// Define REG_SLICE_FLUSH_EN to add the synchronous flush port.
module reg_slice
    import reg_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
`ifdef REG_SLICE_FLUSH_EN
    input  logic               flush,
`endif
    output logic [LEVEL_W-1:0] level
);

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             load_main_c;
    logic             main_from_skid_c;
    logic             load_skid_c;

    reg_slice_ctrl u_ctrl (
        .clk              (clk),
        .rstn             (rstn),
        .in_valid         (in_valid),
        .out_ready        (out_ready),
`ifdef REG_SLICE_FLUSH_EN
        .flush            (flush),
`endif
        .in_ready         (in_ready),
        .out_valid        (out_valid),
        .level            (level),
        .load_main_c      (load_main_c),
        .main_from_skid_c (main_from_skid_c),
        .load_skid_c      (load_skid_c)
    );

    // Main register feeds the output; refilled from input or from skid.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            main_q <= '0;
        end else if (load_main_c) begin
            main_q <= main_from_skid_c ? skid_q : in_data;
        end
    end

    // Skid register catches the word accepted while main is stalled.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            skid_q <= '0;
        end else if (load_skid_c) begin
            skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: tb/tb_reg_slice.sv
// Self-checking bench for reg_slice against a queue-based two-entry buffer model.
module tb_reg_slice;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rstn;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [1:0]       level;

    int n_checks;
    int n_fail;

    // Reference: an ordered buffer of capacity two.
    logic [WIDTH-1:0] mq[$];

    reg_slice #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef REG_SLICE_FLUSH_EN
        .flush     (flush),
`endif
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, updating the model from the handshake rules.
    task automatic tick();
        logic             inf;
        logic             outf;
        logic             fl;
        logic [WIDTH-1:0] d;
        inf  = in_valid && (mq.size() < 2);
        outf = out_ready && (mq.size() > 0);
        d    = in_data;
`ifdef REG_SLICE_FLUSH_EN
        fl   = flush;
`else
        fl   = 1'b0;
`endif
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        mq.delete();
        repeat (2) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        in_valid  = 1'b1;
        in_data   = 32'hA5A5A5A5;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        n_checks++; if (out_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL single_out_data got=%h exp=a5a5a5a5", out_data); end
        n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL single_level got=%0d exp=1", level); end
        tick();
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL single_drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        tick();
        in_data = 32'h22;
        tick();
        in_valid = 1'b0;
        in_data  = 32'h33;
        n_checks++; if (level !== 2'd2) begin n_fail++; $display("FAIL fill_level got=%0d exp=2", level); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
        n_checks++; if (out_data !== 32'h11) begin n_fail++; $display("FAIL fill_out_data got=%h exp=11", out_data); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_data !== 32'h22) begin n_fail++; $display("FAIL drain_second got=%h exp=22", out_data); end
        n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL drain_level1 got=%0d exp=1", level); end
        tick();
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL drain_level0 got=%0d exp=0", level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int n_out;
        n_out     = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = WIDTH'(32'h1000 + i);
            n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready cyc=%0d got=%b exp=1", i, in_ready); end
            if (i > 0) begin
                n_checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(32'h1000 + i - 1)) begin
                    n_fail++; $display("FAIL b2b_word cyc=%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 32'h1000 + i - 1);
                end
                if (out_valid === 1'b1) n_out++;
            end
            tick();
        end
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1 || out_data !== WIDTH'(32'h1000 + 99)) begin
            n_fail++; $display("FAIL b2b_last got=%b/%h exp=1/%h", out_valid, out_data, 32'h1000 + 99);
        end
        if (out_valid === 1'b1) n_out++;
        tick();
        n_checks++; if (n_out != 100) begin n_fail++; $display("FAIL b2b_count got=%0d exp=100", n_out); end
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL b2b_final_level got=%0d exp=0", level); end
    endtask

    task automatic test_random();
        logic             prev_stall;
        logic [WIDTH-1:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int i = 0; i < 10000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = WIDTH'($urandom);
            n_checks++; if (level !== 2'(mq.size()) || level > 2'd2) begin
                n_fail++; $display("FAIL rnd_level cyc=%0d got=%0d exp=%0d", i, level, mq.size());
            end
            n_checks++; if (in_ready !== (mq.size() < 2)) begin
                n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", i, in_ready, mq.size() < 2);
            end
            n_checks++; if (out_valid !== (mq.size() > 0)) begin
                n_fail++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", i, out_valid, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                n_checks++; if (out_data !== mq[0]) begin
                    n_fail++; $display("FAIL rnd_out_data cyc=%0d got=%h exp=%h", i, out_data, mq[0]);
                end
            end
            if (prev_stall) begin
                n_checks++; if (out_data !== prev_data) begin
                    n_fail++; $display("FAIL rnd_stall_stable cyc=%0d got=%h exp=%h", i, out_data, prev_data);
                end
            end
            prev_stall = (mq.size() > 0) && !out_ready;
            prev_data  = (mq.size() > 0) ? mq[0] : '0;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hCAFE0001;
        tick();
        in_data = 32'hCAFE0002;
        tick();
        in_valid = 1'b0;
        n_checks++; if (level !== 2'd2) begin n_fail++; $display("FAIL rstmid_pre_level got=%0d exp=2", level); end
        #2;
        rstn = 1'b0;
        #1;
        mq.delete();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rstmid_out_data got=%h exp=0", out_data); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL rstmid_level got=%0d exp=0", level); end
        @(negedge clk);
        rstn     = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h0BADF00D;
        tick();
        in_valid = 1'b0;
        n_checks++; if (level !== 2'd1 || out_data !== 32'h0BADF00D) begin
            n_fail++; $display("FAIL rstmid_after got=%0d/%h exp=1/0badf00d", level, out_data);
        end
        out_ready = 1'b1;
        tick();
    endtask

`ifdef REG_SLICE_FLUSH_EN
    task automatic test_flush();
        logic seen;
        seen      = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0000F1F1;
        tick();
        n_checks++; if (level !== 2'd1) begin n_fail++; $display("FAIL flush_pre_level got=%0d exp=1", level); end
        in_data = 32'h0000BEEF;
        flush   = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", level); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (out_valid === 1'b1 && out_data === 32'h0000BEEF) seen = 1'b1;
            tick();
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_word_leaked got=%b exp=0", seen); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_fill_drain();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef REG_SLICE_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_slice.md
REG_SLICE -- requirements
Module: reg_slice

Interface
- REQ-001 The block SHALL have parameter WIDTH, default 32, giving the payload width in bits (WIDTH >= 1).
- REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
- REQ-003 The block SHALL have port rstn  input  1  reset, asynchronous and active-low.
- REQ-004 The block SHALL have port in_valid  input  1  upstream presents a word.
- REQ-005 The block SHALL have port in_ready  output  1  slice accepts a word this cycle.
- REQ-006 The block SHALL have port in_data  input  WIDTH  upstream payload.
- REQ-007 The block SHALL have port out_valid  output  1  slice presents a word.
- REQ-008 The block SHALL have port out_ready  input  1  downstream accepts the word this cycle.
- REQ-009 The block SHALL have port out_data  output  WIDTH  downstream payload.
- REQ-010 The block SHALL have port level  output  2  number of words held: 0, 1 or 2.
- REQ-011 The block SHALL have port flush  input  1  synchronous discard of held words; present only when REG_SLICE_FLUSH_EN is defined.

Function
- REQ-012 The block SHALL define in_fire as in_valid & in_ready, and out_fire as out_valid & out_ready.
- REQ-013 The block SHALL hold a main register and a skid register, and a state machine with states EMPTY, ONE and FULL.
- REQ-014 The block SHALL decode in_ready, out_valid and level from state flops only: no combinational path from any input to any output.
- REQ-015 The block SHALL drive in_ready = (state != FULL), out_valid = (state != EMPTY), out_data = main register, and level = 0, 1 or 2 for EMPTY, ONE or FULL.
- REQ-016 In EMPTY, on in_fire, the block SHALL load main with in_data and go to ONE; latency from in_fire to out_valid SHALL be exactly 1 cycle.
- REQ-017 In ONE, on in_fire without out_fire, the block SHALL load skid with in_data and go to FULL.
- REQ-018 In ONE, on out_fire without in_fire, the block SHALL go to EMPTY.
- REQ-019 In ONE, on simultaneous in_fire and out_fire, the block SHALL load main with in_data and stay in ONE.
- REQ-020 In FULL, on out_fire, the block SHALL load main from skid and go to ONE; no in_fire is possible in FULL.
- REQ-021 The block SHALL deliver words in order, with none lost or duplicated; sustained throughput SHALL be 1 word/cycle when out_ready is held 1.
- REQ-022 While out_valid = 1 and out_ready = 0, out_data SHALL remain stable.
- REQ-023 The block SHALL ignore in_data whenever in_fire = 0.

Reset
- REQ-024 Asserting rstn low SHALL immediately force state to EMPTY, main = 0 and skid = 0, giving out_valid = 0, in_ready = 1, level = 0 and out_data = 0.
- REQ-025 Reset asserted mid-transfer SHALL discard both held words; the first in_fire after deassertion SHALL be treated as from EMPTY.
- REQ-026 The block SHALL apply no handshake before the first rising clk edge after rstn deasserts.

Configuration
- REQ-027 With REG_SLICE_FLUSH_EN defined, the flush port SHALL exist, and flush = 1 SHALL force state to EMPTY at the next edge, overriding any in_fire or out_fire that cycle; the data registers SHALL be left unchanged.
- REQ-028 With REG_SLICE_FLUSH_EN undefined, the flush port SHALL be absent and the block SHALL behave as if flush = 0.

Structure
- REQ-029 The state enumeration (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2) SHALL live in shared package reg_slice_pkg.
- REQ-030 One sub-module, reg_slice_ctrl, SHALL hold the state machine and produce load enables for main and skid; the datapath SHALL stay in reg_slice.

Verification
- REQ-031 The bench SHALL cover: reset, then in_valid = 1 with in_data = 0xA5A5A5A5 and out_ready = 1 -> next cycle out_valid = 1, out_data = 0xA5A5A5A5, level = 1.
- REQ-032 The bench SHALL cover: out_ready = 0, then push 0x11 and 0x22 -> level = 2, in_ready = 0, out_data = 0x11; then out_ready = 1 -> 0x11 then 0x22 out, level returns to 0.
- REQ-033 The bench SHALL cover: in_valid = 1 and out_ready = 1 for 100 cycles with incrementing data -> 100 words out, in order, 1 per cycle, in_ready held 1.
- REQ-034 The bench SHALL cover: random in_valid and out_ready at 50% each over 10000 cycles -> scoreboard matches, level never exceeds 2, out_data stable while stalled.
- REQ-035 The bench SHALL cover: rstn pulsed low while level = 2 -> out_valid = 0 and out_data = 0 asynchronously, and in_ready = 1.
- REQ-036 The bench SHALL cover, with REG_SLICE_FLUSH_EN defined: flush = 1 with in_fire in the same cycle while level = 1 -> level = 0 next cycle and the pushed word is never output.
